// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and the default link
// parameters that uart_tx and uart_rx must agree on.
package uart_pkg;

  localparam int DEFAULT_CLOCKS_PER_PULSE = 4;
  localparam int DEFAULT_BITS_PER_WORD    = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } uart_tx_state_e;

  // Counter width for a range 0..n-1; always at least one bit so a
  // degenerate range (n == 1) still gives a legal vector.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: accepts one W_IN-bit word per valid/ready handshake and
// sends it as W_IN/BITS_PER_WORD back-to-back 8N1-style frames, word 0 first.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = DEFAULT_CLOCKS_PER_PULSE,
  parameter int BITS_PER_WORD    = DEFAULT_BITS_PER_WORD,
  parameter int W_IN             = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            s_valid,
  input  logic [W_IN-1:0] s_data,
  output logic            s_ready,
  output logic            tx
);

  localparam int NUM_WORDS = W_IN / BITS_PER_WORD;
  localparam int PW        = clog2_min1(CLOCKS_PER_PULSE);
  localparam int BW        = clog2_min1(BITS_PER_WORD + 2);
  localparam int WW        = clog2_min1(NUM_WORDS);

  localparam logic [PW-1:0] PULSE_LAST    = PW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0] BIT_LAST_DATA = BW'(BITS_PER_WORD);
  localparam logic [BW-1:0] BIT_STOP      = BW'(BITS_PER_WORD + 1);
  localparam logic [WW-1:0] WORD_LAST     = WW'(NUM_WORDS - 1);

  if (W_IN % BITS_PER_WORD != 0) begin : g_bad_width
    $error("uart_tx: W_IN must be a multiple of BITS_PER_WORD");
  end
  if (CLOCKS_PER_PULSE < 1) begin : g_bad_pulse
    $error("uart_tx: CLOCKS_PER_PULSE must be at least 1");
  end
  if (BITS_PER_WORD < 1) begin : g_bad_bits
    $error("uart_tx: BITS_PER_WORD must be at least 1");
  end

  uart_tx_state_e  r_state;
  logic [PW-1:0]   r_pulse_cnt;
  logic [BW-1:0]   r_bit_idx;
  logic [WW-1:0]   r_word_idx;
  logic [W_IN-1:0] r_shreg;
  logic            r_tx;
  logic            r_ready;

  logic            w_pulse_end;
  logic            w_word_last;
  logic [W_IN-1:0] w_shifted;

  assign w_pulse_end = (r_pulse_cnt == PULSE_LAST);
  assign w_word_last = (r_word_idx == WORD_LAST);
  assign w_shifted   = r_shreg >> 1;

  // NOTE: every register, including the shift register, is cleared by the
  // async reset so an aborted frame leaves no stale data behind.
  // NOTE: all state updates use non-blocking assignments so every branch
  // sees the pre-edge values of the counters and shift register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_pulse_cnt <= '0;
      r_bit_idx   <= '0;
      r_word_idx  <= '0;
      r_shreg     <= '0;
      r_tx        <= 1'b1;
      r_ready     <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_valid) begin
            r_shreg     <= s_data;
            r_pulse_cnt <= '0;
            r_bit_idx   <= '0;
            r_word_idx  <= '0;
            r_tx        <= 1'b0;
            r_ready     <= 1'b0;
            r_state     <= SEND;
          end
        end

        SEND: begin
          if (!w_pulse_end) begin
            r_pulse_cnt <= r_pulse_cnt + 1'b1;
          end else begin
            r_pulse_cnt <= '0;
            if (r_bit_idx == BIT_STOP) begin
              // Stop bit done: either chain straight into the next word's
              // start bit or release the line.
              if (w_word_last) begin
                r_tx    <= 1'b1;
                r_ready <= 1'b1;
                r_state <= IDLE;
              end else begin
                r_word_idx <= r_word_idx + 1'b1;
                r_bit_idx  <= '0;
                r_tx       <= 1'b0;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              if (r_bit_idx == '0) begin
                r_tx <= r_shreg[0];
              end else begin
                r_shreg <= w_shifted;
                r_tx    <= (r_bit_idx < BIT_LAST_DATA) ? w_shifted[0] : 1'b1;
              end
            end
          end
        end

        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign s_ready = r_ready;
  assign tx      = r_tx;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: every clock of every transfer is compared
// against the line waveform computed arithmetically from the frame format.
module tb_uart_tx;

  localparam int CPP   = 4;
  localparam int BPW   = 8;
  localparam int WIN   = 16;
  localparam int NW    = WIN / BPW;
  localparam int FRAME = BPW + 2;
  localparam int BUSY  = NW * FRAME * CPP;

  logic           clk;
  logic           rstn;
  logic           s_valid;
  logic [WIN-1:0] s_data;
  logic           s_ready;
  logic           tx;

  int n_vec = 0;
  int n_err = 0;

  uart_tx #(
    .CLOCKS_PER_PULSE(CPP),
    .BITS_PER_WORD   (BPW),
    .W_IN            (WIN)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .s_valid(s_valid),
    .s_data (s_data),
    .s_ready(s_ready),
    .tx     (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, expected finish within 2 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level c clocks after the accepting edge.
  function automatic logic exp_tx(input logic [WIN-1:0] w, input int c);
    int b;
    int wd;
    int j;
    b  = c / CPP;
    wd = b / FRAME;
    j  = b % FRAME;
    if (j == 0)         return 1'b0;
    if (j == FRAME - 1) return 1'b1;
    return w[wd*BPW + j - 1];
  endfunction

  // Offer `word`, then check all BUSY clocks plus the first idle clock.
  // While busy, drive busy_word with s_valid high for busy_clocks clocks
  // (busy_clocks > BUSY keeps s_valid high into the next idle cycle).
  task automatic xfer(input logic [WIN-1:0] word, input logic [WIN-1:0] busy_word,
                      input int busy_clocks);
    int n;
    s_data  = word;
    s_valid = 1'b1;
    n = 0;
    while (s_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", s_ready, 1'b1);
    @(posedge clk);
    #1;
    s_data  = busy_word;
    s_valid = (busy_clocks > 0);
    for (int c = 0; c < BUSY; c++) begin
      @(negedge clk);
      check($sformatf("tx[%h]@%0d", word, c), tx, exp_tx(word, c));
      check($sformatf("busy[%h]@%0d", word, c), s_ready, 1'b0);
      if (c + 1 == busy_clocks) s_valid = 1'b0;
    end
    @(negedge clk);
    check($sformatf("idle_ready[%h]", word), s_ready, 1'b1);
    check($sformatf("idle_tx[%h]", word), tx, 1'b1);
  endtask

  initial begin
    int n;
    int gap;
    logic [WIN-1:0] w;

    rstn    = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'hFFFF;
    repeat (2) begin
      @(negedge clk);
      check("rst_tx", tx, 1'b1);
      check("rst_ready", s_ready, 1'b1);
    end
    rstn = 1'b1;
    #1;
    check("post_rst_tx", tx, 1'b1);
    check("post_rst_ready", s_ready, 1'b1);

    // First edge after release accepts the word.
    xfer(16'hA53C, 16'h0000, 0);

    // Busy-time traffic must be ignored.
    xfer(16'hA53C, 16'h1234, 10);

    // Back-to-back: s_valid stays high through the first idle cycle.
    xfer(16'h00FF, 16'hFF00, BUSY + 1);
    xfer(16'hFF00, 16'h0000, 0);

    // Reset 30 clocks into a transfer.
    s_data  = 16'h9C3A;
    s_valid = 1'b1;
    n = 0;
    while (s_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_ready_wait", s_ready, 1'b1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_pre_busy", s_ready, 1'b0);
    #1;
    rstn = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_ready", s_ready, 1'b1);
    @(negedge clk);
    check("mid_hold_tx", tx, 1'b1);
    rstn = 1'b1;
    xfer(16'h5555, 16'h0000, 0);

    // Random words with random idle gaps.
    for (int i = 0; i < 30; i++) begin
      w   = WIN'($urandom);
      gap = $urandom_range(0, 20);
      s_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check("gap_tx", tx, 1'b1);
        check("gap_ready", s_ready, 1'b1);
      end
      xfer(w, WIN'($urandom), $urandom_range(0, BUSY));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
